// File: rtl/risc_datapath.sv
// VeriRISC execution datapath: phase counter, PC, IR, accumulator, ALU and
// memory address mux, sequenced by the controller's per-phase strobes.
module risc_datapath #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              halt,
    input  logic              inc_pc,
    input  logic              ld_ac,
    input  logic              ld_pc,
    input  logic              wr,
    input  logic              data_e,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [2:0]        opcode,
    output logic [2:0]        phase,
    output logic              zero,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              halted
);

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    logic [2:0]        phase_q;
    logic [AWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] ir_q;
    logic [DWIDTH-1:0] ac_q;
    logic [DWIDTH-1:0] alu_res;
    logic              halted_q;
    logic              run;

    // Non-ALU opcodes leave the accumulator untouched.
    function automatic logic [DWIDTH-1:0] alu(input logic [2:0]        op,
                                              input logic [DWIDTH-1:0] acc,
                                              input logic [DWIDTH-1:0] data);
        logic [DWIDTH-1:0] res;
        case (opcode_e'(op))
            OP_ADD:  res = acc + data;
            OP_AND:  res = acc & data;
            OP_XOR:  res = acc ^ data;
            OP_LDA:  res = data;
            default: res = acc;
        endcase
        return res;
    endfunction

    assign run     = ~halted_q;
    assign alu_res = alu(ir_q[DWIDTH-1 -: 3], ac_q, mem_rdata);

    // Phase stays parked on the halt edge so the frozen state reads back as phase 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 3'd0;
            halted_q <= 1'b0;
        end else if (run) begin
            if (halt) begin
                halted_q <= 1'b1;
            end else begin
                phase_q <= phase_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q <= '0;
        end else if (run && ld_ir) begin
            ir_q <= mem_rdata;
        end
    end

    // A jump wins over the increment when both strobes are present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else if (run) begin
            if (ld_pc) begin
                pc_q <= ir_q[AWIDTH-1:0];
            end else if (inc_pc) begin
                pc_q <= pc_q + AWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_q <= '0;
        end else if (run && ld_ac) begin
            ac_q <= alu_res;
        end
    end

    assign opcode    = ir_q[DWIDTH-1 -: 3];
    assign phase     = phase_q;
    assign zero      = (ac_q == '0);
    assign mem_addr  = sel ? pc_q : ir_q[AWIDTH-1:0];
    assign mem_rd    = rd;
    assign mem_wr    = wr & ~halted_q;
    assign mem_wdata = data_e ? ac_q : '0;
    assign halted    = halted_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Bench for risc_datapath: a behavioural controller drives the strobes, a memory
// array serves the bus, and an instruction-level model predicts the outcome.
module tb_risc_datapath;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    opcode, phase;
    logic          zero, mem_rd, mem_wr, halted;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic [DW-1:0] mem     [32];
    logic [DW-1:0] mem_ref [32];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ac;
    logic [DW-1:0] m_ir;
    logic          m_halted;

    int vectors     = 0;
    int miscompares = 0;

    risc_datapath #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt),
        .inc_pc(inc_pc), .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e),
        .mem_rdata(mem_rdata), .opcode(opcode), .phase(phase), .zero(zero),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller behaviour: strobes as a function of phase, opcode and zero.
    task automatic set_strobes(input int k, input logic [2:0] op, input logic z);
        logic aluop;
        aluop  = (op >= 3'd2) && (op <= 3'd5);
        sel    = (k < 4);
        rd     = (k >= 1 && k <= 3) || (k >= 5 && aluop);
        ld_ir  = (k == 2 || k == 3);
        halt   = (k == 4 && op == 3'd0);
        inc_pc = (k == 4) || (k == 6 && op == 3'd1 && z);
        ld_pc  = (k >= 6 && op == 3'd7);
        ld_ac  = (k == 7 && aluop);
        wr     = (k == 7 && op == 3'd6);
        data_e = (k == 0) || wr;
    endtask

    task automatic tick(input int k, input logic [DW-1:0] ir, input logic [AW-1:0] pc0);
        logic [AW-1:0] ea;
        set_strobes(k, ir[7:5], m_ac == '0);
        #1;
        mem_rdata = mem[mem_addr];
        #1;
        ea = (k < 4) ? pc0 : ir[AW-1:0];
        check("phase", 32'(phase), 32'(k));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        if (k >= 3) check("opcode", 32'(opcode), 32'(ir[7:5]));
        check("zero", 32'(zero), 32'(m_ac == '0));
        check("halted", 32'(halted), 32'(0));
        check("mem_rd", 32'(mem_rd), 32'(rd));
        check("mem_wr", 32'(mem_wr), 32'(wr));
        check("mem_wdata", 32'(mem_wdata), data_e ? 32'(m_ac) : 32'(0));
        if (mem_wr) mem[mem_addr] = mem_wdata;
        @(posedge clk);
        #1;
    endtask

    // Executes one instruction on the DUT and advances the ISA-level model.
    task automatic run_instr();
        logic [DW-1:0] ir;
        logic [2:0]    op;
        logic [AW-1:0] a, pc0;
        pc0 = m_pc;
        ir  = mem_ref[m_pc];
        op  = ir[7:5];
        a   = ir[AW-1:0];
        for (int k = 0; k < 8; k++) begin
            tick(k, ir, pc0);
            if (op == 3'd0 && k == 4) break;
        end
        m_ir = ir;
        m_pc = pc0 + 5'd1;
        case (op)
            3'd0: m_halted = 1'b1;
            3'd1: if (m_ac == '0) m_pc = pc0 + 5'd2;
            3'd2: m_ac = m_ac + mem_ref[a];
            3'd3: m_ac = m_ac & mem_ref[a];
            3'd4: m_ac = m_ac ^ mem_ref[a];
            3'd5: m_ac = mem_ref[a];
            3'd6: mem_ref[a] = m_ac;
            default: m_pc = a;
        endcase
    endtask

    task automatic hold_halted();
        for (int i = 0; i < 20; i++) begin
            {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, data_e} = 8'($urandom);
            wr        = 1'b1;
            mem_rdata = 8'($urandom);
            #1;
            check("hold_phase", 32'(phase), 32'(4));
            check("hold_halted", 32'(halted), 32'(1));
            check("hold_mem_wr", 32'(mem_wr), 32'(0));
            check("hold_addr", 32'(mem_addr), sel ? 32'(m_pc) : 32'(m_ir[AW-1:0]));
            check("hold_opcode", 32'(opcode), 32'(m_ir[7:5]));
            check("hold_wdata", 32'(mem_wdata), data_e ? 32'(m_ac) : 32'(0));
            check("hold_zero", 32'(zero), 32'(m_ac == '0));
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; rst is released well before the next one.
    task automatic do_reset();
        rst = 1'b1;
        {rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr} = '0;
        sel = 1'b1; data_e = 1'b1; mem_rdata = '0;
        #1;
        check("rst_phase", 32'(phase), 32'(0));
        check("rst_pc", 32'(mem_addr), 32'(0));
        check("rst_ac", 32'(mem_wdata), 32'(0));
        check("rst_zero", 32'(zero), 32'(1));
        check("rst_opcode", 32'(opcode), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        sel = 1'b0;
        #1;
        check("rst_ir_addr", 32'(mem_addr), 32'(0));
        #1;
        rst      = 1'b0;
        m_pc     = '0;
        m_ac     = '0;
        m_ir     = '0;
        m_halted = 1'b0;
    endtask

    // Reads PC and AC back through the bus at a phase-0 boundary.
    task automatic probe(input string tag, input logic [AW-1:0] epc, input logic [DW-1:0] eac);
        {rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr} = '0;
        sel = 1'b1; data_e = 1'b1;
        #1;
        check({tag, "_pc"}, 32'(mem_addr), 32'(epc));
        check({tag, "_ac"}, 32'(mem_wdata), 32'(eac));
        check({tag, "_zero"}, 32'(zero), 32'(eac == '0));
        check({tag, "_phase"}, 32'(phase), 32'(0));
    endtask

    task automatic load_mem(input int addr, input logic [DW-1:0] w);
        mem[addr]     = w;
        mem_ref[addr] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) load_mem(i, 8'h00);
    endtask

    task automatic randomize_mem();
        logic [DW-1:0] w;
        for (int i = 0; i < 32; i++) begin
            w = 8'($urandom);
            if (w[7:5] == 3'd0 && $urandom_range(0, 7) != 0) w[7:5] = 3'($urandom_range(1, 7));
            load_mem(i, w);
        end
    endtask

    task automatic load_prog_a(input logic [DW-1:0] addend);
        clear_mem();
        load_mem(0, 8'hA3);  load_mem(1, 8'h50);  load_mem(2, 8'h20);
        load_mem(3, 8'hFF);  load_mem(4, 8'hBD);  load_mem(5, 8'h20);
        load_mem(6, 8'hC9);  load_mem(7, 8'hFF);  load_mem(31, 8'h6A);
        load_mem(16, addend); load_mem(29, 8'h3C); load_mem(10, 8'h0F);
    endtask

    initial begin
        {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e} = '0;
        mem_rdata = '0;
        @(posedge clk);
        #1;

        // Fetch and LDA from reset
        clear_mem();
        load_mem(0, 8'hA3); load_mem(3, 8'h55);
        do_reset();
        run_instr();
        probe("t1", 5'd1, 8'h55);

        // ADD with carry discarded, then an ADD that lands on zero
        load_prog_a(8'h02);
        do_reset();
        run_instr(); run_instr();
        probe("t2a", 5'd2, 8'h01);
        load_prog_a(8'h01);
        do_reset();
        run_instr(); run_instr();
        probe("t2b", 5'd2, 8'h00);

        // SKZ taken and not taken, STO, JMP and PC wrap
        run_instr();
        probe("t3_skip", 5'd4, 8'h00);
        run_instr(); run_instr();
        probe("t3_noskip", 5'd6, 8'h3C);
        run_instr();
        check("t5_mem9", 32'(mem[9]), 32'h3C);
        run_instr();
        probe("t4_jmp", 5'h1F, 8'h3C);
        run_instr();
        probe("t4_wrap", 5'd0, 8'h0C);

        // HLT at PC=2 freezes everything for 20 clocks
        clear_mem();
        load_mem(0, 8'hA3); load_mem(1, 8'h50); load_mem(2, 8'h00);
        load_mem(3, 8'h10); load_mem(16, 8'h01);
        do_reset();
        run_instr(); run_instr(); run_instr();
        hold_halted();
        sel = 1'b1; data_e = 1'b0; #1;
        check("t6_pc", 32'(mem_addr), 32'd3);
        check("t6_halted", 32'(halted), 32'd1);

        // Asynchronous reset mid-instruction, then a clean restart at address 0
        load_prog_a(8'h01);
        do_reset();
        run_instr(); run_instr();
        for (int k = 0; k < 5; k++) tick(k, mem_ref[2], 5'd2);
        do_reset();
        run_instr();
        probe("t7_restart", 5'd1, 8'hFF);

        // Random programs against the instruction-level model
        randomize_mem();
        do_reset();
        for (int n = 0; n < 150; n++) begin
            run_instr();
            if (m_halted) begin
                hold_halted();
                randomize_mem();
                do_reset();
            end
        end
        probe("rand_end", m_pc, m_ac);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
